// File: rtl/noise_gen_multi.sv
`default_nettype none
// ============================================================================
// Module      : noise_gen_multi
// Description : Multi-mode noise source. A Fibonacci LFSR is stepped at a
//               button-adjustable rate. Its top bits are scaled by a
//               button-adjustable gain and presented as white, smoothed,
//               binary or muted offset-binary samples.
// Revision    : 1.0 - initial release
// ============================================================================
module noise_gen_multi #(
    parameter int          WIDTH        = 8,
    parameter int          LFSR_W       = 16,
    parameter logic [31:0] SEED         = 32'h0000_ACE1,
    parameter int          GAIN_BITS    = 3,
    parameter int          GAIN_DEFAULT = 7,
    parameter int          DIV_W        = 16,
    parameter int          DIV_DEFAULT  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 gain_inc,
    input  logic                 gain_dec,
    input  logic                 rate_inc,
    input  logic                 rate_dec,
    input  logic [1:0]           mode,
    input  logic                 reseed,
    output logic [WIDTH-1:0]     noise_out,
    output logic                 sample_valid,
    output logic [GAIN_BITS-1:0] gain,
    output logic [DIV_W-1:0]     rate_div
);

    // Seed truncated to the register length; an all-zero seed would lock up.
    localparam logic [LFSR_W-1:0]       c_SEED_T    = SEED[LFSR_W-1:0];
    localparam logic [LFSR_W-1:0]       c_SEED      = (c_SEED_T == '0) ? LFSR_W'(1) : c_SEED_T;
    localparam logic [GAIN_BITS-1:0]    c_GAIN_MAX  = '1;
    localparam logic [GAIN_BITS-1:0]    c_GAIN_RST  = GAIN_BITS'(GAIN_DEFAULT);
    localparam logic [DIV_W-1:0]        c_DIV_MAX   = '1;
    localparam logic [DIV_W-1:0]        c_DIV_RST   = DIV_W'(DIV_DEFAULT);
    localparam logic signed [WIDTH-1:0] c_POS_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] c_NEG_MAX   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]        c_MIDSCALE  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [1:0]              c_MODE_WHITE  = 2'd0;
    localparam logic [1:0]              c_MODE_SMOOTH = 2'd1;
    localparam logic [1:0]              c_MODE_BINARY = 2'd2;

    // Button bit order: {rate_dec, rate_inc, gain_dec, gain_inc}
    logic [3:0]              r_btn_s1;
    logic [3:0]              r_btn_s2;
    logic [3:0]              r_btn_s3;
    logic [3:0]              w_btn_rise;

    logic [GAIN_BITS-1:0]    r_gain;
    logic [DIV_W-1:0]        r_div;
    logic [DIV_W-1:0]        r_cnt;
    logic [LFSR_W-1:0]       r_lfsr;
    logic                    r_tick_d;
    logic signed [WIDTH-1:0] r_f;
    logic [WIDTH-1:0]        r_noise_out;
    logic                    r_valid;

    logic                    w_tick;
    logic                    w_emit;
    logic                    w_feedback;
    logic [GAIN_BITS-1:0]    w_shift;
    logic signed [WIDTH-1:0] w_x;
    logic signed [WIDTH-1:0] w_a;
    logic signed [WIDTH:0]   w_diff;
    logic signed [WIDTH:0]   w_step;
    logic signed [WIDTH:0]   w_sum;
    logic signed [WIDTH-1:0] w_f_next;
    logic signed [WIDTH-1:0] w_mag;
    logic signed [WIDTH-1:0] w_y;

    assign w_btn_rise   = r_btn_s2 & ~r_btn_s3;
    assign w_tick       = enable && (r_cnt == '0);
    // A tick taken just before enable drops is held and emitted on resume.
    assign w_emit       = enable && r_tick_d;

    assign noise_out    = r_noise_out;
    assign sample_valid = r_valid;
    assign gain         = r_gain;
    assign rate_div     = r_div;

    // Feedback taps for the supported maximal-length register sizes.
    generate
        if (LFSR_W == 8) begin : g_taps_8
            assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
        end else if (LFSR_W == 16) begin : g_taps_16
            assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
        end else if (LFSR_W == 24) begin : g_taps_24
            assign w_feedback = r_lfsr[23] ^ r_lfsr[22] ^ r_lfsr[21] ^ r_lfsr[16];
        end else if (LFSR_W == 32) begin : g_taps_32
            assign w_feedback = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];
        end else begin : g_taps_other
            // Unsupported length: still runs, but the sequence is not maximal.
            assign w_feedback = r_lfsr[LFSR_W-1] ^ r_lfsr[0];
        end
    endgenerate

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_btn_s3 <= '0;
        end else begin
            r_btn_s1 <= {rate_dec, rate_inc, gain_dec, gain_inc};
            r_btn_s2 <= r_btn_s1;
            r_btn_s3 <= r_btn_s2;
        end
    end

    // Saturating gain stepper; opposing presses in one cycle cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gain <= c_GAIN_RST;
        end else if (w_btn_rise[0] && !w_btn_rise[1] && (r_gain != c_GAIN_MAX)) begin
            r_gain <= r_gain + GAIN_BITS'(1);
        end else if (w_btn_rise[1] && !w_btn_rise[0] && (r_gain != '0)) begin
            r_gain <= r_gain - GAIN_BITS'(1);
        end
    end

    // Rate divider reload: halve to go faster, double-plus-one to go slower.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= c_DIV_RST;
        end else if (w_btn_rise[2] && !w_btn_rise[3]) begin
            r_div <= r_div >> 1;
        end else if (w_btn_rise[3] && !w_btn_rise[2] && (r_div != c_DIV_MAX)) begin
            r_div <= {r_div[DIV_W-2:0], 1'b1};
        end
    end

    // Down-counter producing one tick per rate_div+1 enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= c_DIV_RST;
        end else if (enable) begin
            r_cnt <= (r_cnt == '0) ? r_div : r_cnt - DIV_W'(1);
        end
    end

    // LFSR steps on tick; reseed wins over a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= c_SEED;
        end else if (reseed) begin
            r_lfsr <= c_SEED;
        end else if (w_tick) begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_feedback};
        end
    end

    // Delay the tick one cycle so the sample is formed from the new LFSR value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_d <= 1'b0;
        end else if (enable) begin
            r_tick_d <= w_tick;
        end
    end

    // Gain scaling, one-pole smoother and mode selection.
    always_comb begin
        w_shift  = c_GAIN_MAX - r_gain;
        w_x      = r_lfsr[LFSR_W-1 -: WIDTH];
        w_a      = w_x >>> w_shift;
        w_diff   = {w_a[WIDTH-1], w_a} - {r_f[WIDTH-1], r_f};
        w_step   = w_diff >>> 2;
        w_sum    = {r_f[WIDTH-1], r_f} + w_step;
        w_f_next = w_sum[WIDTH-1:0];
        if (w_sum[WIDTH] != w_sum[WIDTH-1]) begin
            w_f_next = w_sum[WIDTH] ? c_NEG_MAX : c_POS_MAX;
        end
        w_mag    = c_POS_MAX >>> w_shift;
        case (mode)
            c_MODE_WHITE:  w_y = w_a;
            c_MODE_SMOOTH: w_y = w_f_next;
            c_MODE_BINARY: w_y = w_x[WIDTH-1] ? -w_mag : w_mag;
            default:       w_y = '0;
        endcase
    end

    // Smoothing state runs on every emitted sample regardless of mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f <= '0;
        end else if (w_emit) begin
            r_f <= w_f_next;
        end
    end

    // Register the offset-binary sample and its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_noise_out <= c_MIDSCALE;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= w_emit;
            if (w_emit) begin
                r_noise_out <= {~w_y[WIDTH-1], w_y[WIDTH-2:0]};
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/noise_gen_multi.md
# noise_gen_multi

Parametrised multi-mode noise source for the signal-generator test path. Produces offset-binary noise samples of configurable width from a configurable-length Fibonacci LFSR, with button-driven gain and sample-rate control plus white, smoothed, binary and mute modes. Drives the DAC/analog test output and the audio-processing input mux in place of the fixed 8-bit, 4-bit-LFSR generator.

## Interface
Parameters:
- `WIDTH`, 8: output sample width; 4..LFSR_W.
- `LFSR_W`, 16: LFSR length; legal values 8, 16, 24, 32 only.
- `SEED`, 16'hACE1: reset/reseed value, truncated to LFSR_W; all-zero replaced by 1.
- `GAIN_BITS`, 3: gain register width.
- `GAIN_DEFAULT`, 7: gain after reset.
- `DIV_W`, 16: rate divider width.
- `DIV_DEFAULT`, 0: divider reload after reset (one sample every DIV_DEFAULT+1 cycles).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  run when high; freeze when low.
- `gain_inc`, `gain_dec`, `rate_inc`, `rate_dec`  in  1 each  raw button levels, asynchronous.
- `mode`  in  2  0 white, 1 smoothed, 2 binary, 3 mute.
- `reseed`  in  1  synchronous pulse; reloads LFSR with SEED.
- `noise_out`  out  WIDTH  offset-binary sample (midscale = 2^(WIDTH-1)).
- `sample_valid`  out  1  one-cycle strobe per new sample.
- `gain`  out  GAIN_BITS  current gain.
- `rate_div`  out  DIV_W  current divider reload.

## Operation
- Buttons: each passes a 2-flop synchroniser, then rising-edge detect; one press = one step.
- Gain: inc +1, saturate at 2^GAIN_BITS-1; dec -1, saturate at 0; both edges same cycle: no change. Shift amount s = (2^GAIN_BITS-1) - gain.
- Rate: rate_inc: div <= div>>1; rate_dec: div <= (div<<1)|1, saturate at all-ones; both same cycle: no change.
- Divider: counter loads `rate_div` on reset/tick, decrements; tick when counter==0 and enable.
- LFSR on tick: shift left, feedback into bit 0 = XOR of taps: 8: 7,5,4,3; 16: 15,13,12,10; 24: 23,22,21,16; 32: 31,21,1,0. Maximal length 2^LFSR_W-1.
- reseed: loads SEED next edge, overrides a coincident tick; counter unaffected.
- Sample path (signed, WIDTH bits): x = lfsr[LFSR_W-1 -: WIDTH]; a = x >>> s.
  - white: y = a.
  - smoothed: y = f where f <= f + ((a - f) >>> 2), computed WIDTH+1 bits, saturated to WIDTH; f updates only on tick.
  - binary: y = x[WIDTH-1] ? -M : +M, M = (2^(WIDTH-1)-1) >>> s.
  - mute: y = 0.
- noise_out = y with MSB inverted.
- mode change takes effect at next sample; smoothing state f keeps running regardless of mode.
- enable low: counter, LFSR, f, noise_out held; sample_valid 0; gain/rate still respond to buttons.

## Timing
- Reset values: LFSR = SEED, f = 0, noise_out = 2^(WIDTH-1), sample_valid 0, gain = GAIN_DEFAULT, rate_div = DIV_DEFAULT, counter = DIV_DEFAULT, synchronisers 0.
- Tick in cycle N: LFSR updates at end of N; noise_out and sample_valid registered at end of N+1 (latency 2 from tick).
- sample_valid period = rate_div+1 cycles; with rate_div=0, valid every cycle after 2-cycle fill.
- Button level rise to gain/rate_div change: 3 clk edges.
- rate_div change takes effect at next counter reload; current count completes.
- Reset assertion mid-operation: all state to reset values immediately, no partial sample.

## Test plan
- Reset, defaults (WIDTH 8, LFSR_W 16): noise_out=0x80, gain=7, rate_div=0, sample_valid=0.
- Release reset, enable=1, mode 0: first sample_valid shows LFSR 0x59C3, noise_out=0xD9; LFSR returns to 0xACE1 after exactly 65535 ticks, never 0.
- Three gain_dec presses then mode 2: gain=4, s=3, noise_out alternates only between 0x8F and 0x71; ten gain_inc presses: gain saturates at 7; simultaneous inc/dec edge: unchanged.
- rate_dec x3: rate_div=7, sample_valid exactly every 8 cycles; rate_inc x5: rate_div=0, no underflow.
- Mode 3: noise_out=0x80 constant; enable low for 20 cycles: no valid, LFSR frozen, resumes with next sequence value.
- reseed pulse coincident with tick: next LFSR=0xACE1; rst_n low mid-run: outputs at reset values within same cycle.
